ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage and consumes `id_to_ex_bus`.
- Holds the ID/EX pipeline register.
- Performs ALU ops, load/store address generation and the data-SRAM request.
- Owns HI/LO with single-cycle mult/multu and an iterative 32-cycle div/divu.
- Produces `ex_to_mem_bus` for MEM and `ex_to_rf_bus` for decode-stage forwarding.

Parameters:
- DIV_ITERS, 32, radix-2 divider iterations. Fixed for 32-bit datapath; not user-tunable.

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high; clock `clk`.
- stall  in  `StallBus` (6)  pipeline stall vector. Bit 2 = IF/ID→EX boundary, bit 3 = EX→MEM boundary. `Stop` = 1.
- id_to_ex_bus  in  159  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
- ex_to_mem_bus  out  76  {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_to_rf_bus  out  38  {rf_we, rf_waddr, ex_result} forwarded to decode
- data_sram_en  out  1  data SRAM enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  32  = ALU result
- data_sram_wdata  out  32  = rdata2
- stallreq_for_ex  out  1  request to stall the pipeline while the divider is busy

Behaviour:
- Pipeline register update (priority order):
  - rst → 0.
  - Else stall[2]=Stop & stall[3]=NoStop → load 0 (bubble).
  - Else stall[2]=NoStop → load `id_to_ex_bus`.
  - Else hold.
  - All outputs derive from the register, so every output is 0 after reset (HI=LO=0, divider IDLE).
- ALU source 1 (one-hot): [0] rdata1, [1] pc, [2] zero-extended inst[10:6]. No bit set → 0.
- ALU source 2 (one-hot): [0] rdata2, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0]. No bit set → 0.
- ALU operation: `alu_op` is one-hot, bit 11→0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub wrap mod 2^32, no overflow trap.
  - slt is signed, sltu unsigned; result is 0/1.
  - Shifts use src1[4:0] as amount on src2.
  - lui = {src2[15:0], 16'h0}.
  - Zero `alu_op` → result 0.
- HI/LO ops are decoded locally from inst (opcode 0): mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mfhi 0x10, mflo 0x12, mthi 0x11, mtlo 0x13.
  - mfhi/mflo: ex_result = HI/LO; rf_we forced 1; rf_waddr = inst[15:11].
  - mthi/mtlo: HI/LO ← rdata1 at the clock edge.
  - mult/multu: {HI,LO} ← 64-bit signed/unsigned product, same cycle.
  - All HI/LO writes are gated by stall[2]=NoStop, so each write happens once.
- Data SRAM: data_sram_en = data_ram_en; data_sram_wen = data_ram_wen; address = ALU result.
- Divider FSM (sub-module):
  - IDLE: div/divu in register → latch |rs|, |rt| (signed) or raw values; count=0; go RUN; stallreq=1.
  - RUN: one restoring iteration per cycle; stallreq=1; after iteration 31 → DONE.
  - DONE: stallreq=0; apply sign fix (quotient negative if signs differ, remainder takes the dividend's sign); LO←quotient, HI←remainder at the edge where stall[2]=NoStop; then → IDLE.
  - Total stallreq high = 33 cycles.
  - Divide by zero is not trapped: divu x/0 → LO=0xFFFFFFFF, HI=x.
  - rst in any state → IDLE, HI/LO=0, stallreq=0.
- Forwarding bus: `ex_to_rf_bus` carries the current-cycle ex_result. For loads, ex_result = address; decode already stalls loads.

Decomposition:
- Add ID_TO_EX_WD=159, EX_TO_MEM_WD=76, EX_TO_RF_WD=38, the func codes above and the alu_op bit indices to lib/defines.vh.
- One sub-module: `div_iter` (FSM + 32-bit restoring divider, start/signed/done/quotient/remainder).
- Multiplier stays inline using the `*` operator.

Test Plan:
- addu rs=0x7FFFFFFF, rt=1, rd=5 → ex_result=0x80000000; ex_to_rf_bus={1,5,0x80000000} one cycle after load.
- sw base=0x1000, imm=-4, rt=0xDEADBEEF → sram en=1, wen=4'hF, addr=0x0FFC, wdata=0xDEADBEEF.
- div rs=-7, rt=2 → stallreq high exactly 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; following mflo writes 0xFFFFFFFD.
- divu rs=5, rt=0 → LO=0xFFFFFFFF, HI=5; multu 0xFFFFFFFF*2 → HI=1, LO=0xFFFFFFFE.
- stall[2]=1, stall[3]=0 for 1 cycle → ex_to_mem_bus=0 that cycle; stall[2]=stall[3]=1 → bus held.
- rst asserted at div iteration 10 → next cycle stallreq=0, HI=LO=0, all outputs 0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared widths, decode constants and the ID/EX register layout for the execute stage.
package ex_stage_pkg;
  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int DIV_ITERS    = 32;

  localparam int   STALL_ID_EX  = 2;
  localparam int   STALL_EX_MEM = 3;
  localparam logic STOP         = 1'b1;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction
endpackage

// File: rtl/ex_stage_div_iter.sv
// Radix-2 restoring divider: operands latched as magnitudes, sign fixed on the way out.
// state | meaning: IDLE wait for start | RUN one quotient bit per cycle | DONE result held until ack
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic        ack,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        negq_q, negq_d, negr_q, negr_d;
  logic [32:0] rem_sh, rem_diff;
  logic        ge;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    rem_sh   = {rem_q, quo_q[31]};
    rem_diff = rem_sh - {1'b0, dvs_q};
    ge       = rem_sh >= {1'b0, dvs_q};
    case (state_q)
      DIV_IDLE: if (start) begin
        quo_d   = signed_op ? abs32(dividend) : dividend;
        dvs_d   = signed_op ? abs32(divisor) : divisor;
        rem_d   = '0;
        cnt_d   = '0;
        negq_d  = signed_op & (dividend[31] ^ divisor[31]);
        negr_d  = signed_op & dividend[31];
        state_d = DIV_RUN;
      end
      DIV_RUN: begin
        quo_d = {quo_q[30:0], ge};
        rem_d = ge ? rem_diff[31:0] : rem_sh[31:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) state_d = DIV_DONE;
      end
      DIV_DONE: if (ack) state_d = DIV_IDLE;
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign busy      = ((state_q == DIV_IDLE) && start) || (state_q == DIV_RUN);
  assign done      = state_q == DIV_DONE;
  assign quotient  = negq_q ? (~quo_q + 32'd1) : quo_q;
  assign remainder = negr_q ? (~rem_q + 32'd1) : rem_q;
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data-SRAM request, HI/LO with mult and iterative divide.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);
  id_ex_t      id_ex_q, id_ex_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] inst, src1, src2, alu_res, ex_result, div_quo, div_rem;
  logic [63:0] prod;
  logic        hilo_wr, is_special, is_mult, is_multu, is_div, is_divu;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo, div_done;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        unused_bits;

  // A stopped EX with a moving MEM must emit a bubble, not replay the held op.
  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[STALL_ID_EX] == STOP && stall[STALL_EX_MEM] != STOP) id_ex_d = '0;
    else if (stall[STALL_ID_EX] != STOP) id_ex_d = id_ex_t'(id_to_ex_bus);
  end

  assign inst       = id_ex_q.inst;
  assign is_special = inst[31:26] == 6'd0;
  assign is_mult    = is_special && inst[5:0] == FN_MULT;
  assign is_multu   = is_special && inst[5:0] == FN_MULTU;
  assign is_div     = is_special && inst[5:0] == FN_DIV;
  assign is_divu    = is_special && inst[5:0] == FN_DIVU;
  assign is_mfhi    = is_special && inst[5:0] == FN_MFHI;
  assign is_mflo    = is_special && inst[5:0] == FN_MFLO;
  assign is_mthi    = is_special && inst[5:0] == FN_MTHI;
  assign is_mtlo    = is_special && inst[5:0] == FN_MTLO;
  assign hilo_wr    = stall[STALL_ID_EX] != STOP;

  always_comb begin
    src1 = '0;
    if (id_ex_q.sel_alu_src1[0])      src1 = id_ex_q.rdata1;
    else if (id_ex_q.sel_alu_src1[1]) src1 = id_ex_q.pc;
    else if (id_ex_q.sel_alu_src1[2]) src1 = {27'd0, inst[10:6]};
    src2 = '0;
    if (id_ex_q.sel_alu_src2[0])      src2 = id_ex_q.rdata2;
    else if (id_ex_q.sel_alu_src2[1]) src2 = {{16{inst[15]}}, inst[15:0]};
    else if (id_ex_q.sel_alu_src2[2]) src2 = 32'd8;
    else if (id_ex_q.sel_alu_src2[3]) src2 = {16'd0, inst[15:0]};
  end

  always_comb begin
    alu_res = '0;
    if (id_ex_q.alu_op[ALU_ADD])       alu_res = src1 + src2;
    else if (id_ex_q.alu_op[ALU_SUB])  alu_res = src1 - src2;
    else if (id_ex_q.alu_op[ALU_SLT])  alu_res = {31'd0, $signed(src1) < $signed(src2)};
    else if (id_ex_q.alu_op[ALU_SLTU]) alu_res = {31'd0, src1 < src2};
    else if (id_ex_q.alu_op[ALU_AND])  alu_res = src1 & src2;
    else if (id_ex_q.alu_op[ALU_NOR])  alu_res = ~(src1 | src2);
    else if (id_ex_q.alu_op[ALU_OR])   alu_res = src1 | src2;
    else if (id_ex_q.alu_op[ALU_XOR])  alu_res = src1 ^ src2;
    else if (id_ex_q.alu_op[ALU_SLL])  alu_res = src2 << src1[4:0];
    else if (id_ex_q.alu_op[ALU_SRL])  alu_res = src2 >> src1[4:0];
    else if (id_ex_q.alu_op[ALU_SRA])  alu_res = $signed(src2) >>> src1[4:0];
    else if (id_ex_q.alu_op[ALU_LUI])  alu_res = {src2[15:0], 16'h0};
  end

  always_comb begin
    if (is_mult) prod = $signed(id_ex_q.rdata1) * $signed(id_ex_q.rdata2);
    else         prod = {32'd0, id_ex_q.rdata1} * {32'd0, id_ex_q.rdata2};
  end

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div | is_divu),
    .signed_op (is_div),
    .ack       (hilo_wr),
    .dividend  (id_ex_q.rdata1),
    .divisor   (id_ex_q.rdata2),
    .busy      (stallreq_for_ex),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Writes only on an advancing edge so a stalled op never updates HI/LO twice.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_wr) begin
      if (is_mthi) hi_d = id_ex_q.rdata1;
      if (is_mtlo) lo_d = id_ex_q.rdata1;
      if (is_mult || is_multu) {hi_d, lo_d} = prod;
      if (div_done) begin
        hi_d = div_rem;
        lo_d = div_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      id_ex_q <= id_ex_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
  assign rf_we     = id_ex_q.rf_we | is_mfhi | is_mflo;
  assign rf_waddr  = (is_mfhi || is_mflo) ? inst[15:11] : id_ex_q.rf_waddr;

  assign ex_to_mem_bus   = {id_ex_q.pc, id_ex_q.data_ram_en, id_ex_q.data_ram_wen,
                            id_ex_q.sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign data_sram_en    = id_ex_q.data_ram_en;
  assign data_sram_wen   = id_ex_q.data_ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = id_ex_q.rdata2;
  assign unused_bits     = ^{inst[25:16], stall[5:4], stall[1:0]};
endmodule
